// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: several masters share one slave port,
// with a registered one-hot grant and a watchdog that aborts hung slave cycles.
module wb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                    wb_clk_i,
    input  logic                                    wb_rst_n_i,
    input  logic [NUM_MASTERS-1:0]                  wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]                  wbm_stb_i,
    input  logic [NUM_MASTERS-1:0]                  wbm_we_i,
    input  logic [NUM_MASTERS*BUS_DATA_WIDTH/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS*BUS_ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*BUS_DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [BUS_DATA_WIDTH-1:0]               wbm_dat_o,
    output logic [NUM_MASTERS-1:0]                  wbm_ack_o,
    output logic [NUM_MASTERS-1:0]                  wbm_err_o,
    output logic                                    wbs_cyc_o,
    output logic                                    wbs_stb_o,
    output logic                                    wbs_we_o,
    output logic [BUS_DATA_WIDTH/8-1:0]             wbs_sel_o,
    output logic [BUS_ADDR_WIDTH-1:0]               wbs_adr_o,
    output logic [BUS_DATA_WIDTH-1:0]               wbs_dat_o,
    input  logic [BUS_DATA_WIDTH-1:0]               wbs_dat_i,
    input  logic                                    wbs_ack_i,
    input  logic                                    wbs_err_i,
    output logic [NUM_MASTERS-1:0]                  gnt_o,
    output logic                                    timeout_o
);

    localparam int unsigned NM    = NUM_MASTERS;
    localparam int          SEL_W = BUS_DATA_WIDTH / 8;
    localparam int          IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ABORT
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;

    logic                   owned, busy, abort;
    logic                   m_cyc, m_stb, stall, rearb;
    logic                   arb_found;
    logic [IDX_W-1:0]       arb_idx, cand;

    // While a grant is held, last_q is the owner's index.
    assign owned = |gnt_q;
    assign busy  = (state_q == BUSY);
    assign abort = (state_q == ABORT);
    assign m_cyc = owned & wbm_cyc_i[last_q];
    assign m_stb = owned & wbm_stb_i[last_q];

    assign wbs_cyc_o = busy & m_cyc;
    assign wbs_stb_o = busy & m_stb;
    assign wbs_we_o  = owned & wbm_we_i[last_q];
    assign wbs_sel_o = owned ? wbm_sel_i[last_q*SEL_W +: SEL_W] : '0;
    assign wbs_adr_o = owned ? wbm_adr_i[last_q*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH] : '0;
    assign wbs_dat_o = owned ? wbm_dat_i[last_q*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] : '0;

    assign wbm_ack_o = busy ? (gnt_q & {NUM_MASTERS{wbs_ack_i}}) : '0;
    assign wbm_err_o = abort ? gnt_q :
                       busy  ? (gnt_q & {NUM_MASTERS{wbs_err_i}}) : '0;
    assign wbm_dat_o = owned ? wbs_dat_i : '0;

    assign gnt_o     = gnt_q;
    assign timeout_o = timeout_q;

    assign stall = wbs_stb_o & ~wbs_ack_i & ~wbs_err_i;

    // Search last+1, last+2, ... so the previous owner is considered last.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = last_q;
        cand      = last_q;
        for (int unsigned i = 1; i <= NM; i++) begin
            cand = IDX_W'((32'(last_q) + i) % NM);
            if (!arb_found && wbm_cyc_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        rearb     = 1'b0;

        unique case (state_q)
            IDLE: rearb = 1'b1;
            BUSY: begin
                if (!m_cyc) begin
                    rearb = 1'b1;
                end else if (WD_EN && stall) begin
                    if (cnt_q == WD_LAST) begin
                        state_d   = ABORT;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ABORT: begin
                if (!m_stb) begin
                    if (m_cyc) begin
                        state_d = BUSY;
                        cnt_d   = '0;
                    end else begin
                        rearb = 1'b1;
                    end
                end
            end
            default: rearb = 1'b1;
        endcase

        if (rearb) begin
            cnt_d = '0;
            gnt_d = '0;
            if (arb_found) begin
                state_d        = BUSY;
                gnt_d[arb_idx] = 1'b1;
                last_d         = arb_idx;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            last_q    <= IDX_W'(NM - 1);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin Wishbone arbiter that shares one Wishbone slave port (e.g. `sys_block` or any register-mapped slave) between up to eight masters. It registers the grant, multiplexes the granted master's request onto the slave and routes `ack` and `err` back to that master only. A watchdog aborts slave cycles that never acknowledge. It sits between the bus masters (host interface, DMA, debug) and the shared slave.

## Interface
- `NUM_MASTERS`, 4: number of requesters, 2..8.
- `BUS_DATA_WIDTH`, 32: data width, a multiple of 8 (8/16/32/64).
- `BUS_ADDR_WIDTH`, 8: address width.
- `TIMEOUT_CYCLES`, 255: slave no-ack limit, 1..65535; 0 disables the watchdog.
- `wb_clk_i` input 1: clock. One clock; all logic on its rising edge.
- `wb_rst_n_i` input 1: reset, asynchronous, active-low.
- `wbm_cyc_i` input NUM_MASTERS: per-master cycle (request).
- `wbm_stb_i` input NUM_MASTERS: per-master strobe.
- `wbm_we_i` input NUM_MASTERS: per-master write enable.
- `wbm_sel_i` input NUM_MASTERS*BUS_DATA_WIDTH/8: byte enables; master m at slice m.
- `wbm_adr_i` input NUM_MASTERS*BUS_ADDR_WIDTH: addresses, sliced per master.
- `wbm_dat_i` input NUM_MASTERS*BUS_DATA_WIDTH: write data, sliced per master.
- `wbm_dat_o` output BUS_DATA_WIDTH: read data, broadcast to all masters.
- `wbm_ack_o` output NUM_MASTERS: ack; only the granted bit can be 1.
- `wbm_err_o` output NUM_MASTERS: error (slave err or watchdog); only the granted bit can be 1.
- `wbs_cyc_o`, `wbs_stb_o`, `wbs_we_o` output 1 each: to slave.
- `wbs_sel_o`, `wbs_adr_o`, `wbs_dat_o` output BE/AW/DW: to slave.
- `wbs_dat_i`, `wbs_ack_i`, `wbs_err_i` input DW/1/1: from slave.
- `gnt_o` output NUM_MASTERS: registered one-hot grant; all zero means no owner.
- `timeout_o` output 1: one-cycle pulse when the watchdog fires.

## Operation
- FSM states: IDLE, BUSY, ABORT. Reset state is IDLE with `gnt_o`=0, `last`=NUM_MASTERS-1 and the watchdog count at 0. While no master is granted, every output is 0.
- **Arbitration.** In IDLE, and in BUSY at the edge where the granted master's `cyc` is low, the next grant goes to the first requester with `wbm_cyc_i` high, searching last+1, last+2, … modulo NUM_MASTERS. `last` then takes the granted index and the state moves to BUSY. If no master is requesting, the state is IDLE.
- **Ownership.** The grant is held for as long as the granted master's `cyc` stays high. There is no preemption; multi-beat cycles are never split.
- **Mux.** The `wbs_*` outputs are a combinational function of the registered grant and the granted master's inputs. `wbm_ack_o[g]` = `wbs_ack_i`. `wbm_err_o[g]` = `wbs_err_i`. `wbm_dat_o` = `wbs_dat_i` while a grant is held, else 0.
- **Watchdog (BUSY).** The count increments each cycle in which `wbs_stb_o`=1, `wbs_ack_i`=0 and `wbs_err_i`=0, and clears otherwise. When TIMEOUT_CYCLES consecutive such cycles are reached, the state moves to ABORT and `timeout_o` pulses.
- **ABORT.**
  - `wbs_cyc_o`, `wbs_stb_o`: forced to 0.
  - `wbm_err_o[g]`: 1, held until the master drops `stb`.
  - Exit when the master drops `stb`: to BUSY if its `cyc` is still high (count cleared), otherwise re-arbitrate as above.
- Slave `ack`/`err` arriving in ABORT are ignored.
- **Async reset mid-transfer.** Grant, FSM, count and `last` clear immediately and all outputs go to 0 without waiting for a clock. Any transfer in flight is lost.

## Timing
- Grant latency: a request sampled at edge N gives `gnt_o` and `wbs_stb_o` high in cycle N+1. A slave with registered ack (one-cycle latency) returns `wbm_ack_o` in cycle N+2.
- Handover: the owner drops `cyc` in cycle T. The next requester is granted at edge T+1, with zero idle cycles.
- A slave's registered ack drops at edge T+1, so the new owner never sees a stale ack.
- Watchdog: with stb first seen by the slave in cycle S and no response, `wbm_err_o` and `timeout_o` are high in cycle S+TIMEOUT_CYCLES.
- Simultaneous requests: resolved purely by the round-robin order. A master re-requesting at the same edge it releases has the lowest priority.

## Test plan
- Single read: M1 reads adr 0x00 from sys_block (BOARD_ID=0x5A) → `gnt_o`=4'b0010 one cycle after `cyc`, `wbm_ack_o[1]` next cycle, `wbm_dat_o`=0x5A, other acks stay 0.
- Contention after reset: M0 and M2 request in the same cycle → M0 is served first. M2 is granted the cycle after M0 drops `cyc`, with no idle cycle.
- Fairness: all four masters request continuously with 1-beat cycles → grant order 0,1,2,3,0,1 and no master is skipped.
- Byte-lane write: M3 writes 0xAABBCCDD with sel=4'b0101 to adr 0x04, then reads it back → `wbs_sel_o`=4'b0101 is seen at the slave and the readback is 0x00BB00DD (scratch cleared beforehand).
- Watchdog: TIMEOUT_CYCLES=16, `wbs_ack_i` tied 0 → `wbm_err_o[g]`=1 and `timeout_o` pulse 16 cycles after `stb`. `wbs_stb_o` is 0 during ABORT. After `stb` drops, the next master is granted.
- Reset mid-cycle: `wb_rst_n_i` pulled low between clock edges while M2 owns the bus → `gnt_o`, `wbs_cyc_o` and `wbm_ack_o` read 0 before the next edge. After release, M0 wins arbitration first.
